// File: rtl/rank_filter_pkg.sv
// Shared types and helpers for the streaming rank-order filter.
package rank_filter_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

  // Out-of-range ranks fall back to the median.
  function automatic int clamp_rank(input int rank, input int n);
    return (rank >= n) ? (n - 1) / 2 : rank;
  endfunction

endpackage

// File: rtl/rank_cmp_swap.sv
// Unsigned compare-exchange cell: larger value on hi, smaller on lo.
module rank_cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic swap;

  assign swap = (a < b);
  assign hi   = swap ? b : a;
  assign lo   = swap ? a : b;

endmodule

// File: rtl/rank_filter.sv
// Burst rank-order filter: load N samples, sort with an odd-even transposition
// network (one phase per cycle), then emit the sample at the latched rank.
module rank_filter
  import rank_filter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 9,
  parameter int RW    = $clog2(N)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DSI,
  input  logic [WIDTH-1:0] DI,
  input  logic [RW-1:0]    RANK,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             BUSY,
  output logic             ERR
);

  localparam int CW = $clog2(N + 1);
  localparam int NP = N / 2;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    rk;
  logic [WIDTH-1:0] r  [N];
  logic [WIDTH-1:0] ev [N];
  logic [WIDTH-1:0] od [N];
  logic             last;

  // Even phase pairs (0,1),(2,3)...; odd phase pairs (1,2),(3,4)...
  for (genvar i = 0; i < NP; i++) begin : g_pairs
    rank_cmp_swap #(.WIDTH(WIDTH)) u_even (
      .a (r[2*i]),
      .b (r[2*i+1]),
      .hi(ev[2*i]),
      .lo(ev[2*i+1])
    );
    rank_cmp_swap #(.WIDTH(WIDTH)) u_odd (
      .a (r[2*i+1]),
      .b (r[2*i+2]),
      .hi(od[2*i+1]),
      .lo(od[2*i+2])
    );
  end
  assign ev[N-1] = r[N-1];
  assign od[0]   = r[0];

  assign last = (cnt == CW'(N - 1));
  assign BUSY = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (DSI) state_nxt = LOAD;
      LOAD: begin
        if (!DSI)      state_nxt = IDLE;
        else if (last) state_nxt = SORT;
      end
      SORT: if (last) state_nxt = OUT;
      OUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counter doubles as sample count in LOAD and phase index in SORT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      rk  <= '0;
      DO  <= '0;
      DSO <= 1'b0;
      ERR <= 1'b0;
    end else begin
      DSO <= 1'b0;
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (DSI) begin
            cnt <= CW'(1);
            rk  <= RW'(clamp_rank(int'(RANK), N));
          end
        end
        LOAD: begin
          if (!DSI) begin
            cnt <= '0;
            ERR <= 1'b1;
          end else begin
            cnt <= last ? '0 : cnt + CW'(1);
          end
        end
        SORT: cnt <= last ? '0 : cnt + CW'(1);
        OUT: begin
          DO  <= r[rk];
          DSO <= 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) r[i] <= '0;
    end else if (DSI && (state == IDLE || state == LOAD)) begin
      r[0] <= DI;
      for (int i = 1; i < N; i++) r[i] <= r[i-1];
    end else if (state == SORT) begin
      for (int i = 0; i < N; i++) r[i] <= cnt[0] ? od[i] : ev[i];
    end
  end

endmodule

// File: tb/tb_rank_filter.sv
// Directed and reference-model checks of rank_filter at (N=9,W=8) and (N=5,W=12).
module tb_rank_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dsi_a = 1'b0, dsi_b = 1'b0;
  logic [7:0]  di_a = '0;
  logic [11:0] di_b = '0;
  logic [3:0]  rank_a = '0;
  logic [2:0]  rank_b = '0;
  logic [7:0]  do_a;
  logic [11:0] do_b;
  logic        dso_a, dso_b, busy_a, busy_b, err_a, err_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic busy_load_ok;

  always #5 clk = ~clk;

  rank_filter #(.WIDTH(8), .N(9)) dut_a (
    .CLK(clk), .RST(rst), .DSI(dsi_a), .DI(di_a), .RANK(rank_a),
    .DO(do_a), .DSO(dso_a), .BUSY(busy_a), .ERR(err_a)
  );

  rank_filter #(.WIDTH(12), .N(5)) dut_b (
    .CLK(clk), .RST(rst), .DSI(dsi_b), .DI(di_b), .RANK(rank_b),
    .DO(do_b), .DSO(dso_b), .BUSY(busy_b), .ERR(err_b)
  );

  function automatic logic sel_dso(input int sel);
    return (sel == 0) ? dso_a : dso_b;
  endfunction

  function automatic logic sel_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  function automatic int sel_do(input int sel);
    return (sel == 0) ? int'(do_a) : int'(do_b);
  endfunction

  function automatic int ref_rank(input int s[15], input int n, input int rank);
    int v[15];
    int t;
    int k;
    v = s;
    for (int i = 1; i < n; i++) begin
      t = v[i];
      k = i - 1;
      while (k >= 0 && v[k] < t) begin
        v[k+1] = v[k];
        k--;
      end
      v[k+1] = t;
    end
    return v[(rank >= n) ? (n - 1) / 2 : rank];
  endfunction

  // Call at a negedge; first sample is driven immediately.
  task automatic drive_burst(input int sel, input int n, input int s[15], input int rank);
    busy_load_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (!sel_busy(sel)) busy_load_ok = 1'b0;
      end
      if (sel == 0) begin
        dsi_a = 1'b1; di_a = 8'(s[i]); rank_a = 4'(rank);
      end else begin
        dsi_b = 1'b1; di_b = 12'(s[i]); rank_b = 3'(rank);
      end
    end
    @(negedge clk);
    if (!sel_busy(sel)) busy_load_ok = 1'b0;
    dsi_a = 1'b0;
    dsi_b = 1'b0;
  endtask

  task automatic wait_dso(input int sel, input int n, output int lat, output int val,
                          output logic busy_ok);
    lat = -1;
    val = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 2 * n + 2; k++) begin
      @(negedge clk);
      if (sel_dso(sel)) begin
        lat = k;
        val = sel_do(sel);
        if (sel_busy(sel)) busy_ok = 1'b0;
        break;
      end else if (!sel_busy(sel)) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({do_a, dso_a, busy_a, err_a} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_a: got do=%0d dso=%b busy=%b err=%b, want all 0", do_a, dso_a, busy_a, err_a);
    end
    n_checks++;
    if ({do_b, dso_b, busy_b, err_b} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_b: got do=%0d dso=%b busy=%b err=%b, want all 0", do_b, dso_b, busy_b, err_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_median;
    int s[15] = '{10, 200, 30, 40, 250, 60, 70, 80, 90, 0, 0, 0, 0, 0, 0};
    int lat, val;
    logic bok;
    drive_burst(0, 9, s, 4);
    wait_dso(0, 9, lat, val, bok);
    n_checks++;
    if (val !== 70) begin n_fail++; $display("FAIL median_value: got %0d want 70", val); end
    n_checks++;
    if (lat !== 10) begin n_fail++; $display("FAIL median_latency: got %0d want 10", lat); end
    n_checks++;
    if (!(busy_load_ok && bok)) begin
      n_fail++;
      $display("FAIL median_busy: got load_ok=%b sort_ok=%b want 1 1", busy_load_ok, bok);
    end
    @(negedge clk);
    n_checks++;
    if (dso_a !== 1'b0 || do_a !== 8'd70) begin
      n_fail++;
      $display("FAIL median_hold: got dso=%b do=%0d want dso=0 do=70", dso_a, do_a);
    end
  endtask

  task automatic test_extreme_ranks;
    int s[15] = '{10, 200, 30, 40, 250, 60, 70, 80, 90, 0, 0, 0, 0, 0, 0};
    int ranks[3] = '{0, 8, 13};
    int exps[3]  = '{250, 10, 70};
    int lat, val;
    logic bok;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      drive_burst(0, 9, s, ranks[t]);
      wait_dso(0, 9, lat, val, bok);
      n_checks++;
      if (val !== exps[t] || lat !== 10) begin
        n_fail++;
        $display("FAIL extreme_rank%0d: got %0d (lat %0d) want %0d (lat 10)", ranks[t], val, lat, exps[t]);
      end
    end
  endtask

  task automatic test_duplicates;
    int s1[15] = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 0, 0, 0, 0, 0, 0};
    int s2[15] = '{5, 5, 5, 1, 1, 1, 9, 9, 9, 0, 0, 0, 0, 0, 0};
    int lat, val;
    logic bok;
    @(negedge clk);
    drive_burst(0, 9, s1, 4);
    wait_dso(0, 9, lat, val, bok);
    n_checks++;
    if (val !== 255) begin n_fail++; $display("FAIL dup_all255: got %0d want 255", val); end
    @(negedge clk);
    drive_burst(0, 9, s2, 4);
    wait_dso(0, 9, lat, val, bok);
    n_checks++;
    if (val !== 5) begin n_fail++; $display("FAIL dup_mixed: got %0d want 5", val); end
  endtask

  task automatic test_abort;
    int s[15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0};
    int lat, val;
    int err_cnt = 0;
    logic saw_dso = 1'b0;
    logic bok;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      dsi_a = 1'b1; di_a = 8'(40 + i); rank_a = 4'd4;
    end
    @(negedge clk);
    dsi_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_a !== 1'b1) begin n_fail++; $display("FAIL abort_err: got %b want 1", err_a); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (err_a) err_cnt++;
      if (dso_a) saw_dso = 1'b1;
    end
    n_checks++;
    if (err_cnt !== 0 || saw_dso !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_aftermath: got extra_err=%0d dso=%b want 0 0", err_cnt, saw_dso);
    end
    drive_burst(0, 9, s, 4);
    wait_dso(0, 9, lat, val, bok);
    n_checks++;
    if (val !== 5 || lat !== 10) begin
      n_fail++;
      $display("FAIL abort_recover: got %0d (lat %0d) want 5 (lat 10)", val, lat);
    end
  endtask

  task automatic test_reset_mid_sort;
    int s[15] = '{10, 200, 30, 40, 250, 60, 70, 80, 90, 0, 0, 0, 0, 0, 0};
    logic seen = 1'b0;
    @(negedge clk);
    drive_burst(0, 9, s, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({do_a, dso_a, busy_a, err_a} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid_sort: got do=%0d dso=%b busy=%b err=%b want all 0", do_a, dso_a, busy_a, err_a);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dso_a || err_a) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_output: got dso/err=1 want 0"); end
  endtask

  task automatic test_back_to_back;
    int s1[15] = '{10, 200, 30, 40, 250, 60, 70, 80, 90, 0, 0, 0, 0, 0, 0};
    int s2[15] = '{9, 1, 8, 2, 7, 3, 6, 4, 5, 0, 0, 0, 0, 0, 0};
    int lat, val;
    logic bok;
    @(negedge clk);
    drive_burst(0, 9, s1, 4);
    wait_dso(0, 9, lat, val, bok);
    n_checks++;
    if (val !== 70 || lat !== 10) begin
      n_fail++;
      $display("FAIL b2b_first: got %0d (lat %0d) want 70 (lat 10)", val, lat);
    end
    drive_burst(0, 9, s2, 4);
    wait_dso(0, 9, lat, val, bok);
    n_checks++;
    if (val !== 5 || lat !== 10) begin
      n_fail++;
      $display("FAIL b2b_second: got %0d (lat %0d) want 5 (lat 10)", val, lat);
    end
  endtask

  task automatic test_random(input int sel, input int n, input int maxv, input int maxr);
    int s[15];
    int lat, val, expv, rank;
    logic bok;
    @(negedge clk);
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < 15; i++) begin
        s[i] = (i >= n) ? 0 : ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3)
                                                           : $urandom_range(0, maxv);
      end
      rank = $urandom_range(0, maxr);
      expv = ref_rank(s, n, rank);
      drive_burst(sel, n, s, rank);
      wait_dso(sel, n, lat, val, bok);
      n_checks++;
      if (val !== expv || lat !== n + 1) begin
        n_fail++;
        $display("FAIL random_n%0d_burst%0d: got %0d (lat %0d) want %0d (lat %0d)",
                 n, b, val, lat, expv, n + 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_median();
    test_extreme_ranks();
    test_duplicates();
    test_abort();
    test_reset_mid_sort();
    test_back_to_back();
    test_random(0, 9, 255, 15);
    test_random(1, 5, 4095, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
